// File: rtl/hpm_counter_unit.sv
// Hardware performance monitor: NUM_CNT event counters with per-counter event selectors,
// inhibit mask, sticky overflow status, interrupt enable and a one-cycle-latency register port.
module hpm_counter_unit #(
  parameter int NUM_CNT = 4,
  parameter int NUM_EVT = 16,
  parameter int CNT_W   = 64,
  parameter int DATA_W  = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              debug_mode_i,
  input  logic [NUM_EVT-1:0] event_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [5:0]        addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rvalid_o,
  output logic              irq_o
);

  localparam int SEL_W = $clog2(NUM_EVT + 1);

  logic [CNT_W-1:0]   cnt_q [NUM_CNT];
  logic [SEL_W-1:0]   sel_q [NUM_CNT];
  logic [NUM_CNT-1:0] inhibit_q;
  logic [NUM_CNT-1:0] ovf_q;
  logic [NUM_CNT-1:0] irq_en_q;

  logic [NUM_CNT-1:0] inc;
  logic [NUM_CNT-1:0] wrap;
  logic [NUM_CNT-1:0] cnt_wr;
  logic [NUM_CNT-1:0] sel_wr;
  logic [NUM_CNT-1:0] ovf_w1c;
  logic [DATA_W-1:0]  rd_val;
  logic               wr_en;
  logic               is_fixed;
  logic               unused_wdata;

  assign wr_en        = req_i & we_i;
  assign unused_wdata = ^wdata_i;
  // The fixed registers at 32..34 take precedence over selector slots that would alias them.
  assign is_fixed     = (addr_i == 6'd32) || (addr_i == 6'd33) || (addr_i == 6'd34);

  for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
    logic hit;

    always_comb begin
      hit = 1'b0;
      for (int k = 0; k < NUM_EVT; k++) begin
        if (sel_q[gi] == SEL_W'(k + 1)) hit = hit | event_i[k];
      end
    end

    assign inc[gi]    = hit & ~inhibit_q[gi] & ~debug_mode_i;
    assign wrap[gi]   = inc[gi] & (&cnt_q[gi]);
    assign cnt_wr[gi] = wr_en && (addr_i == 6'(gi));
    assign sel_wr[gi] = wr_en && (addr_i == 6'(NUM_CNT + gi)) && !is_fixed;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q[gi] <= '0;
        sel_q[gi] <= '0;
      end else begin
        if (cnt_wr[gi]) begin
          cnt_q[gi] <= wdata_i[CNT_W-1:0];
        end else if (inc[gi]) begin
          cnt_q[gi] <= cnt_q[gi] + CNT_W'(1);
        end
        if (sel_wr[gi]) sel_q[gi] <= wdata_i[SEL_W-1:0];
      end
    end
  end

  assign ovf_w1c = (wr_en && addr_i == 6'd33) ? wdata_i[NUM_CNT-1:0] : '0;

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (addr_i == 6'(i)) rd_val = DATA_W'(cnt_q[i]);
      if (addr_i == 6'(NUM_CNT + i) && !is_fixed) rd_val = DATA_W'(sel_q[i]);
    end
    case (addr_i)
      6'd32:   rd_val = DATA_W'(inhibit_q);
      6'd33:   rd_val = DATA_W'(ovf_q);
      6'd34:   rd_val = DATA_W'(irq_en_q);
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inhibit_q <= '0;
      ovf_q     <= '0;
      irq_en_q  <= '0;
      rvalid_o  <= 1'b0;
      rdata_o   <= '0;
      irq_o     <= 1'b0;
    end else begin
      if (wr_en && addr_i == 6'd32) inhibit_q <= wdata_i[NUM_CNT-1:0];
      if (wr_en && addr_i == 6'd34) irq_en_q  <= wdata_i[NUM_CNT-1:0];
      // A written counter never overflows; a fresh overflow beats a same-cycle clear.
      ovf_q    <= (ovf_q & ~ovf_w1c) | (wrap & ~cnt_wr);
      rvalid_o <= req_i;
      rdata_o  <= req_i ? rd_val : '0;
      irq_o    <= |(ovf_q & irq_en_q);
    end
  end

endmodule

// File: tb/tb_hpm_counter_unit.sv
// Directed bench for hpm_counter_unit (CNT_W=8) with a cycle-level reference model
// checked every cycle, plus literal expectations on directed reads.
module tb_hpm_counter_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        debug_mode_i = 1'b0;
  logic [15:0] event_i = '0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [5:0]  addr_i = '0;
  logic [63:0] wdata_i = '0;
  logic [63:0] rdata_o;
  logic        rvalid_o;
  logic        irq_o;

  int checks = 0;
  int failures = 0;

  hpm_counter_unit #(.NUM_CNT(4), .NUM_EVT(16), .CNT_W(8), .DATA_W(64)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .debug_mode_i(debug_mode_i), .event_i(event_i),
    .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .rdata_o(rdata_o), .rvalid_o(rvalid_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference state: plain integers, counters modulo 256
  int unsigned m_cnt [4] = '{0, 0, 0, 0};
  int unsigned m_sel [4] = '{0, 0, 0, 0};
  int unsigned m_inh = 0, m_ovf = 0, m_ien = 0;
  logic        exp_rvalid = 1'b0;
  logic [63:0] exp_rdata = '0;
  logic        exp_irq = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic written(input int a);
    return req_i && we_i && (int'(addr_i) == a);
  endfunction

  function automatic logic counts(input int i);
    int unsigned s;
    s = m_sel[i];
    if (debug_mode_i || ((m_inh >> i) & 1) != 0) return 1'b0;
    if (s < 1 || s > 16) return 1'b0;
    return event_i[s-1];
  endfunction

  function automatic int unsigned wrap_mask();
    int unsigned m;
    m = 0;
    for (int i = 0; i < 4; i++)
      if (counts(i) && m_cnt[i] == 255 && !written(i)) m |= (1 << i);
    return m;
  endfunction

  function automatic logic [63:0] reg_value(input int a);
    if (a < 4) return 64'(m_cnt[a]);
    if (a < 8) return 64'(m_sel[a-4]);
    if (a == 32) return 64'(m_inh);
    if (a == 33) return 64'(m_ovf);
    if (a == 34) return 64'(m_ien);
    return 64'd0;
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 4; i++) begin
        m_cnt[i] <= 0;
        m_sel[i] <= 0;
      end
      m_inh <= 0; m_ovf <= 0; m_ien <= 0;
      exp_rvalid <= 1'b0; exp_rdata <= '0; exp_irq <= 1'b0;
    end else begin
      exp_irq    <= (m_ovf & m_ien) != 0;
      exp_rvalid <= req_i;
      exp_rdata  <= req_i ? reg_value(int'(addr_i)) : 64'd0;
      for (int i = 0; i < 4; i++) begin
        if (written(i)) m_cnt[i] <= int'(wdata_i % 256);
        else if (counts(i)) m_cnt[i] <= (m_cnt[i] + 1) % 256;
        if (written(4 + i)) m_sel[i] <= int'(wdata_i % 32);
      end
      if (written(32)) m_inh <= int'(wdata_i % 16);
      if (written(34)) m_ien <= int'(wdata_i % 16);
      m_ovf <= (written(33) ? (m_ovf & ~int'(wdata_i % 16)) : m_ovf) | wrap_mask();
    end
  end

  always @(negedge clk_i) begin
    chk("cyc_rvalid", rvalid_o, exp_rvalid);
    chk("cyc_rdata", rdata_o, exp_rdata);
    chk("cyc_irq", irq_o, exp_irq);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [63:0] d);
    req_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d;
    tick();
    req_i = 1'b0; we_i = 1'b0; wdata_i = '0;
    $display("write addr=%0d data=%0h", a, d);
  endtask

  task automatic rd_expect(input logic [5:0] a, input logic [63:0] e, input string nm);
    req_i = 1'b1; we_i = 1'b0; addr_i = a;
    tick();
    req_i = 1'b0;
    @(negedge clk_i);
    chk({nm, "_rvalid"}, rvalid_o, 1'b1);
    chk(nm, rdata_o, e);
    $display("read  addr=%0d data=%0h expect=%0h", a, rdata_o, e);
  endtask

  task automatic hold(input logic [15:0] ev, input int n);
    event_i = ev;
    repeat (n) tick();
    event_i = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    rst_ni = 1'b1;
    rd_expect(6'd0, 64'd0, "rst_cnt0");
    rd_expect(6'd33, 64'd0, "rst_ovf");
    rd_expect(6'd34, 64'd0, "rst_ien");

    // Ten events on selector 3
    wr(6'd4, 64'd3);
    hold(16'h0004, 10);
    rd_expect(6'd0, 64'd10, "cnt0_ten");

    // 8-bit wrap with interrupt
    wr(6'd5, 64'd1);
    wr(6'd34, 64'd2);
    wr(6'd1, 64'hFF);
    hold(16'h0001, 1);
    @(negedge clk_i);
    chk("irq_not_yet", irq_o, 1'b0);
    @(negedge clk_i);
    chk("irq_set", irq_o, 1'b1);
    rd_expect(6'd1, 64'd0, "cnt1_wrapped");
    rd_expect(6'd33, 64'd2, "ovf_after_wrap");

    // Write beats increment; overflow beats W1C
    event_i = 16'h0004;
    wr(6'd0, 64'h50);
    event_i = '0;
    rd_expect(6'd0, 64'h50, "cnt0_write_wins");
    wr(6'd1, 64'hFF);
    event_i = 16'h0001;
    wr(6'd33, 64'd2);
    event_i = '0;
    rd_expect(6'd33, 64'd2, "ovf_w1c_vs_wrap");
    wr(6'd33, 64'd2);
    rd_expect(6'd33, 64'd0, "ovf_w1c");

    // Inhibit and debug freeze
    wr(6'd32, 64'd1);
    wr(6'd5, 64'd3);
    hold(16'h0004, 5);
    debug_mode_i = 1'b1;
    hold(16'h0004, 5);
    rd_expect(6'd1, 64'd5, "cnt1_debug_frozen");
    rd_expect(6'd0, 64'h50, "cnt0_inhibited");
    wr(6'd1, 64'h20);
    rd_expect(6'd1, 64'h20, "cnt1_debug_write");
    debug_mode_i = 1'b0;

    // Out-of-range selector and unmapped address
    wr(6'd6, 64'd17);
    hold(16'hFFFF, 4);
    rd_expect(6'd2, 64'd0, "cnt2_sel_oor");
    rd_expect(6'd1, 64'h24, "cnt1_all_events");
    rd_expect(6'd40, 64'd0, "unmapped_rd");
    wr(6'd40, 64'hFFFF);
    rd_expect(6'd40, 64'd0, "unmapped_wr");
    rd_expect(6'd6, 64'd17, "sel2_value");
    rd_expect(6'd3, 64'd0, "cnt3_idle");

    // Reset mid-count with a response in flight
    wr(6'd32, 64'd0);
    wr(6'd1, 64'hFF);
    hold(16'h0004, 1);
    tick();
    @(negedge clk_i);
    chk("irq_before_rst", irq_o, 1'b1);
    event_i = 16'h0004;
    tick();
    req_i = 1'b1; addr_i = 6'd0;
    tick();
    req_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("rst_rvalid", rvalid_o, 1'b0);
    chk("rst_rdata", rdata_o, 64'd0);
    chk("rst_irq", irq_o, 1'b0);
    repeat (3) tick();
    rst_ni = 1'b1;
    hold(16'h0004, 3);
    rd_expect(6'd0, 64'd0, "post_rst_cnt0");
    rd_expect(6'd1, 64'd0, "post_rst_cnt1");
    rd_expect(6'd4, 64'd0, "post_rst_sel0");
    rd_expect(6'd33, 64'd0, "post_rst_ovf");
    rd_expect(6'd34, 64'd0, "post_rst_ien");
    rd_expect(6'd32, 64'd0, "post_rst_inh");

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
